// File: rtl/ram_burst_if.sv
// ----------------------------------------------------------------------------
// ram_burst_if
// Command / data handshake bundle between a bus master (or DMA sequencer) and
// the ram_burst storage block.
//   Cmd*      : burst command (valid/ready, direction, start address, length)
//   Wr*       : write beat stream into the RAM (valid/ready)
//   RdData/RdValid : read beat stream out of the RAM (no back-pressure)
//   Busy, Done, InitDone : status
// Modports: master drives commands and write beats, slave is the RAM.
// ----------------------------------------------------------------------------
interface ram_burst_if #(
    parameter int DW = 8,
    parameter int AW = 10,
    parameter int LW = 4
);
    logic          CmdValid;
    logic          CmdReady;
    logic          CmdRWS;
    logic [AW-1:0] CmdAddr;
    logic [LW-1:0] CmdLen;
    logic [DW-1:0] WrData;
    logic          WrValid;
    logic          WrReady;
    logic [DW-1:0] RdData;
    logic          RdValid;
    logic          Busy;
    logic          Done;
    logic          InitDone;

    modport master (
        output CmdValid, CmdRWS, CmdAddr, CmdLen, WrData, WrValid,
        input  CmdReady, WrReady, RdData, RdValid, Busy, Done, InitDone
    );

    modport slave (
        input  CmdValid, CmdRWS, CmdAddr, CmdLen, WrData, WrValid,
        output CmdReady, WrReady, RdData, RdValid, Busy, Done, InitDone
    );
endinterface

// File: rtl/ram_burst.sv
// ----------------------------------------------------------------------------
// ram_burst
// Single-port synchronous RAM (2^AW x DW) with a burst command front end.
// After every reset the whole array is swept to zero before commands are
// accepted. Each command moves CmdLen+1 beats starting at CmdAddr; the address
// auto-increments and wraps modulo 2^AW.
// Ports:
//   clk   : clock, all activity on the rising edge
//   rst_n : synchronous active-low reset
//   bus   : ram_burst_if.slave (command, write beats, read beats, status)
// ----------------------------------------------------------------------------
module ram_burst #(
    parameter int DW = 8,
    parameter int AW = 10,
    parameter int LW = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    ram_burst_if.slave   bus
);

    typedef enum logic [1:0] {
        CLEAR,
        IDLE,
        WRITE,
        READ
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [LW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] clr_ptr_q, clr_ptr_d;
    logic          init_done_q, init_done_d;
    logic          done_q, done_d;
    logic          rd_valid_q, rd_valid_d;
    logic [DW-1:0] rd_data_q;

    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          rd_en;

    logic [DW-1:0] mem [2**AW];

    // Next-state and memory-port decode.
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned; an unassigned path in always_comb would infer a latch.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        clr_ptr_d   = clr_ptr_q;
        init_done_d = init_done_q;
        done_d      = 1'b0;
        rd_valid_d  = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = ptr_q;
        mem_wdata   = bus.WrData;
        rd_en       = 1'b0;

        unique case (state_q)
            CLEAR: begin
                // Command and write inputs are ignored while sweeping.
                mem_we    = 1'b1;
                mem_addr  = clr_ptr_q;
                mem_wdata = '0;
                clr_ptr_d = clr_ptr_q + AW'(1);
                if (clr_ptr_q == '1) begin
                    state_d     = IDLE;
                    init_done_d = 1'b1;
                end
            end
            IDLE: begin
                if (bus.CmdValid) begin
                    ptr_d   = bus.CmdAddr;
                    cnt_d   = bus.CmdLen;
                    state_d = bus.CmdRWS ? WRITE : READ;
                end
            end
            WRITE: begin
                if (bus.WrValid) begin
                    mem_we = 1'b1;
                    ptr_d  = ptr_q + AW'(1);
                    cnt_d  = cnt_q - LW'(1);
                    if (cnt_q == '0) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            READ: begin
                // Reads never stall; one beat per edge until the count runs out.
                rd_en      = 1'b1;
                rd_valid_d = 1'b1;
                ptr_d      = ptr_q + AW'(1);
                cnt_d      = cnt_q - LW'(1);
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples its _d value from before the edge, independent of block order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= CLEAR;
            ptr_q       <= '0;
            cnt_q       <= '0;
            clr_ptr_q   <= '0;
            init_done_q <= 1'b0;
            done_q      <= 1'b0;
            rd_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            clr_ptr_q   <= clr_ptr_d;
            init_done_q <= init_done_d;
            done_q      <= done_d;
            rd_valid_q  <= rd_valid_d;
        end
    end

    // NOTE: the array itself has no reset so it maps onto a RAM macro; the
    // CLEAR sweep provides the zero contents instead. A beat on the reset
    // edge is dropped.
    always_ff @(posedge clk) begin
        if (rst_n && mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    // Registered read port; the output register itself is cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else if (rd_en) begin
            rd_data_q <= mem[ptr_q];
        end
    end

    assign bus.CmdReady = (state_q == IDLE);
    assign bus.WrReady  = (state_q == WRITE);
    assign bus.Busy     = (state_q != IDLE);
    assign bus.RdData   = rd_data_q;
    assign bus.RdValid  = rd_valid_q;
    assign bus.Done     = done_q;
    assign bus.InitDone = init_done_q;

endmodule

// File: tb/tb_ram_burst.sv
// ----------------------------------------------------------------------------
// tb_ram_burst
// Self-checking bench for ram_burst. A flat array model holds the expected
// memory contents; read commands push their expected beats into a queue and
// a separate monitor pops and compares each RdValid beat.
// ----------------------------------------------------------------------------
module tb_ram_burst;
    localparam int DW    = 8;
    localparam int AW    = 10;
    localparam int LW    = 4;
    localparam int DEPTH = 1 << AW;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ram_burst_if #(.DW(DW), .AW(AW), .LW(LW)) bus ();

    ram_burst #(.DW(DW), .AW(AW), .LW(LW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] model [DEPTH];
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] wdata [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every read beat must match the next expected value.
    always @(negedge clk) begin
        if (bus.RdValid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected RdValid", 32'd1, 32'd0);
            end else begin
                logic [DW-1:0] e;
                e = exp_q.pop_front();
                check("RdData", 32'(bus.RdData), 32'(e));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        int n;
        rst_n = 1'b0;
        repeat (cycles) tick();
        check("rst CmdReady", 32'(bus.CmdReady), 32'd0);
        check("rst WrReady",  32'(bus.WrReady),  32'd0);
        check("rst RdValid",  32'(bus.RdValid),  32'd0);
        check("rst RdData",   32'(bus.RdData),   32'd0);
        check("rst Done",     32'(bus.Done),     32'd0);
        check("rst InitDone", 32'(bus.InitDone), 32'd0);
        check("rst Busy",     32'(bus.Busy),     32'd1);
        exp_q.delete();
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        rst_n = 1'b1;
        n = 0;
        do begin
            bus.CmdValid = $urandom_range(0, 1);
            bus.WrValid  = $urandom_range(0, 1);
            tick();
            n++;
        end while (bus.InitDone !== 1'b1 && n < 2000);
        bus.CmdValid = 1'b0;
        bus.WrValid  = 1'b0;
        check("clear cycles", 32'(n), 32'(DEPTH));
        check("clear CmdReady", 32'(bus.CmdReady), 32'd1);
        check("clear Busy", 32'(bus.Busy), 32'd0);
    endtask

    task automatic issue(input logic rws, input int addr, input int len);
        int n = 0;
        while (bus.CmdReady !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        check("CmdReady before issue", 32'(bus.CmdReady), 32'd1);
        bus.CmdValid = 1'b1;
        bus.CmdRWS   = rws;
        bus.CmdAddr  = AW'(addr);
        bus.CmdLen   = LW'(len);
        tick();
        bus.CmdValid = 1'b0;
        bus.CmdRWS   = 1'($urandom);
        bus.CmdAddr  = AW'($urandom);
        bus.CmdLen   = LW'($urandom);
    endtask

    // Write burst of len+1 beats from wdata; optional stall before beat stall_at.
    task automatic write_burst(input int addr, input int len, input int stall_at,
                               input int stall_n, output int cycles);
        cycles = 0;
        issue(1'b1, addr, len);
        for (int i = 0; i <= len; i++) begin
            if (i == stall_at) begin
                repeat (stall_n) begin
                    bus.WrValid = 1'b0;
                    bus.WrData  = DW'($urandom);
                    check("WrReady stall", 32'(bus.WrReady), 32'd1);
                    tick();
                    cycles++;
                end
            end
            bus.WrValid = 1'b1;
            bus.WrData  = wdata[i];
            check("WrReady beat", 32'(bus.WrReady), 32'd1);
            check("Done before last beat", 32'(bus.Done), 32'd0);
            tick();
            cycles++;
            model[(addr + i) % DEPTH] = wdata[i];
        end
        bus.WrValid = 1'b0;
        check("write Done", 32'(bus.Done), 32'd1);
        check("write WrReady end", 32'(bus.WrReady), 32'd0);
    endtask

    task automatic read_burst(input int addr, input int len);
        issue(1'b0, addr, len);
        for (int i = 0; i <= len; i++) exp_q.push_back(model[(addr + i) % DEPTH]);
        for (int i = 0; i <= len; i++) begin
            tick();
            check("read RdValid", 32'(bus.RdValid), 32'd1);
            check("read Done", 32'(bus.Done), 32'(i == len));
        end
    endtask

    task automatic fill_wdata(input int len, input int base);
        wdata.delete();
        for (int i = 0; i <= len; i++) begin
            if (base < 0) wdata.push_back(DW'($urandom));
            else wdata.push_back(DW'(base + i));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int addrs [5] = '{0, 62, 217, 602, 1015};
        int vals  [5] = '{4, 15, 46, 95, 168};

        bus.CmdValid = 1'b0;
        bus.CmdRWS   = 1'b0;
        bus.CmdAddr  = '0;
        bus.CmdLen   = '0;
        bus.WrData   = '0;
        bus.WrValid  = 1'b0;
        rst_n        = 1'b0;

        // Power-up reset and clear sweep.
        do_reset(2);

        // Reset clear: 0xFF at 5 must be wiped by a one-cycle reset pulse.
        wdata.delete();
        wdata.push_back(8'hFF);
        write_burst(5, 0, -1, 0, cyc);
        read_burst(5, 0);
        do_reset(1);
        read_burst(5, 0);

        // Single-beat writes then reads.
        for (int i = 0; i < 5; i++) begin
            wdata.delete();
            wdata.push_back(DW'(vals[i]));
            write_burst(addrs[i], 0, -1, 0, cyc);
        end
        for (int i = 0; i < 5; i++) read_burst(addrs[i], 0);

        // Wrapping burst 1020..3 with data 1..8.
        fill_wdata(7, 1);
        write_burst(1020, 7, -1, 0, cyc);
        read_burst(1020, 7);
        read_burst(0, 3);

        // Write stall: 4 beats, 3 idle cycles after beat 2.
        fill_wdata(3, 8'h40);
        write_burst(300, 3, 2, 3, cyc);
        check("stall cycles", 32'(cyc), 32'd7);
        read_burst(300, 3);

        // Back-to-back: read accepted in the write's Done cycle.
        fill_wdata(5, -1);
        write_burst(500, 5, -1, 0, cyc);
        check("b2b Done at accept", 32'(bus.Done), 32'd1);
        read_burst(500, 5);
        read_burst(503, 0);

        // Randomized bursts.
        for (int t = 0; t < 40; t++) begin
            int a;
            int l;
            a = $urandom_range(0, DEPTH - 1);
            l = $urandom_range(0, (1 << LW) - 1);
            if ($urandom_range(0, 1) == 1) begin
                fill_wdata(l, -1);
                write_burst(a, l, $urandom_range(0, l), $urandom_range(0, 2), cyc);
                if ($urandom_range(0, 1) == 1) read_burst(a, $urandom_range(0, (1 << LW) - 1));
            end else begin
                read_burst(a, l);
            end
            if ($urandom_range(0, 3) == 0) tick();
        end

        // Reset mid-burst: reset arrives while beat 3 of an 8-beat read is out.
        fill_wdata(7, 8'h90);
        write_burst(1020, 7, -1, 0, cyc);
        issue(1'b0, 1020, 7);
        for (int i = 0; i < 8; i++) exp_q.push_back(model[(1020 + i) % DEPTH]);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("midrst RdValid", 32'(bus.RdValid), 32'd1);
        end
        do_reset(1);
        read_burst(1020, 7);

        tick();
        tick();
        check("scoreboard drained", 32'(exp_q.size()), 32'd0);
        check("idle RdValid", 32'(bus.RdValid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
